compare8_minmax_ctrl: RTL and testbench

//  Sequencer that time-shares one external 8-bit comparator (DataCompare8) to find the max and min of a byte burst.

---
 rtl/compare8_minmax_ctrl.sv | 152 +++++++++++++++
 tb/tb_compare8_minmax_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare8_minmax_ctrl.sv
// Burst max/min finder that time-shares one external combinational 8-bit comparator.
// Optional macro MINMAX_INDEX_EN adds oMaxIdx/oMinIdx burst-position outputs.
module compare8_minmax_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [7:0]       iData,
  input  logic             iLast,
  output logic [7:0]       oCmp_a,
  output logic [7:0]       oCmp_b,
  input  logic [2:0]       iCmp,
  output logic             oBusy,
  output logic             oDone,
  output logic [7:0]       oMax,
  output logic [7:0]       oMin,
  output logic [CNT_W-1:0] oCount,
`ifdef MINMAX_INDEX_EN
  output logic [CNT_W-1:0] oMaxIdx,
  output logic [CNT_W-1:0] oMinIdx,
`endif
  output logic             oErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP_MAX,
    S_CMP_MIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  state_t     nextState;
  logic [7:0] rSample;
  logic       rLast;
  logic       accept;
  logic       cmpOk;
  logic       aGreater;
  logic       aLess;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] rIdx;
`endif

  always_comb begin
    oReady   = (state == S_IDLE);
    oDone    = (state == S_DONE);
    accept   = iValid && oReady;
    cmpOk    = (iCmp == 3'b100) || (iCmp == 3'b010) || (iCmp == 3'b001);
    aGreater = (iCmp == 3'b100);
    aLess    = (iCmp == 3'b001);
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= S_IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          // First sample seeds max/min directly; iLast is used since rLast is loaded on this same edge.
          if (!oBusy) nextState = iLast ? S_DONE : S_IDLE;
          else        nextState = S_CMP_MAX;
        end
      end
      S_CMP_MAX: nextState = S_CMP_MIN;
      S_CMP_MIN: nextState = rLast ? S_DONE : S_IDLE;
      S_DONE:    nextState = S_IDLE;
      default:   nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rSample <= '0;
      rLast   <= 1'b0;
      oBusy   <= 1'b0;
      oErr    <= 1'b0;
      oMax    <= '0;
      oMin    <= '0;
      oCount  <= '0;
      oCmp_a  <= '0;
      oCmp_b  <= '0;
`ifdef MINMAX_INDEX_EN
      rIdx    <= '0;
      oMaxIdx <= '0;
      oMinIdx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rSample <= iData;
            rLast   <= iLast;
            if (!oBusy) begin
              oBusy   <= 1'b1;
              oMax    <= iData;
              oMin    <= iData;
              oCount  <= CNT_ONE;
`ifdef MINMAX_INDEX_EN
              oMaxIdx <= '0;
              oMinIdx <= '0;
`endif
            end else begin
              // Operands are registered here so they are stable for the whole compare cycle.
              oCmp_a <= iData;
              oCmp_b <= oMax;
              if (oCount != CNT_MAX) oCount <= oCount + CNT_ONE;
`ifdef MINMAX_INDEX_EN
              rIdx <= oCount;
`endif
            end
          end
        end
        S_CMP_MAX: begin
          if (!cmpOk) begin
            oErr <= 1'b1;
          end else if (aGreater) begin
            oMax <= rSample;
`ifdef MINMAX_INDEX_EN
            oMaxIdx <= rIdx;
`endif
          end
          oCmp_a <= rSample;
          oCmp_b <= oMin;
        end
        S_CMP_MIN: begin
          if (!cmpOk) begin
            oErr <= 1'b1;
          end else if (aLess) begin
            oMin <= rSample;
`ifdef MINMAX_INDEX_EN
            oMinIdx <= rIdx;
`endif
          end
        end
        S_DONE: begin
          oBusy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compare8_minmax_ctrl.sv
// Scoreboard bench for compare8_minmax_ctrl with an external comparator model.
// Index outputs are checked when MINMAX_INDEX_EN is defined.
module tb_compare8_minmax_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iValid;
  logic             oReady;
  logic [7:0]       iData;
  logic             iLast;
  logic [7:0]       oCmp_a;
  logic [7:0]       oCmp_b;
  logic [2:0]       iCmp;
  logic             oBusy;
  logic             oDone;
  logic [7:0]       oMax;
  logic [7:0]       oMin;
  logic [CNT_W-1:0] oCount;
  logic             oErr;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] oMaxIdx;
  logic [CNT_W-1:0] oMinIdx;
`endif

  compare8_minmax_ctrl #(.CNT_W(CNT_W)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .iLast  (iLast),
    .oCmp_a (oCmp_a),
    .oCmp_b (oCmp_b),
    .iCmp   (iCmp),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oMax   (oMax),
    .oMin   (oMin),
    .oCount (oCount),
`ifdef MINMAX_INDEX_EN
    .oMaxIdx(oMaxIdx),
    .oMinIdx(oMinIdx),
`endif
    .oErr   (oErr)
  );

  always #5 iClk = ~iClk;

  // External comparator; can be forced to an illegal result for one operand value.
  logic       forceBad = 1'b0;
  logic [7:0] badVal   = 8'h00;
  always_comb begin
    if (forceBad && oCmp_a == badVal) iCmp = 3'b000;
    else if (oCmp_a > oCmp_b)         iCmp = 3'b100;
    else if (oCmp_a == oCmp_b)        iCmp = 3'b010;
    else                              iCmp = 3'b001;
  end

  typedef struct {
    int mx;
    int mn;
    int cnt;
    int mxi;
    int mni;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastAcceptNeg = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] v[$]);
    exp_t m;
    m.mx = v[0]; m.mn = v[0]; m.mxi = 0; m.mni = 0;
    for (int i = 1; i < v.size(); i++) begin
      int idx;
      idx = (i > 255) ? 255 : i;
      if (int'(v[i]) > m.mx) begin m.mx = v[i]; m.mxi = idx; end
      if (int'(v[i]) < m.mn) begin m.mn = v[i]; m.mni = idx; end
    end
    m.cnt = (v.size() > 255) ? 255 : v.size();
    return m;
  endfunction

  function automatic exp_t mk(input int mx, input int mn, input int cnt, input int mxi, input int mni);
    exp_t e;
    e.mx = mx; e.mn = mn; e.cnt = cnt; e.mxi = mxi; e.mni = mni;
    return e;
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge iClk) begin
    if (oDone) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("max", int'(oMax), e.mx);
        chk("min", int'(oMin), e.mn);
        chk("count", int'(oCount), e.cnt);
        chk("done_latency", cyc - lastAcceptNeg, (e.cnt == 1) ? 1 : 3);
`ifdef MINMAX_INDEX_EN
        chk("max_idx", int'(oMaxIdx), e.mxi);
        chk("min_idx", int'(oMinIdx), e.mni);
`endif
      end
    end
  end

  // Drives one burst at negedges; gap=0 keeps iValid high across the burst.
  task automatic sendBurst(input logic [7:0] v[$], input bit finalLast, input int gap);
    int prevNeg;
    prevNeg = 0;
    for (int i = 0; i < v.size(); i++) begin
      int waitCyc;
      waitCyc = 0;
      iValid = 1'b1;
      iData  = v[i];
      iLast  = finalLast && (i == v.size() - 1);
      while (!oReady && waitCyc < 20) begin
        @(negedge iClk);
        waitCyc++;
      end
      if (!oReady) begin
        chk("ready_timeout", 0, 1);
        iValid = 1'b0;
        return;
      end
      lastAcceptNeg = cyc;
      if (gap == 0 && i >= 1) chk("accept_spacing", cyc - prevNeg, (i == 1) ? 1 : 3);
      prevNeg = cyc;
      @(posedge iClk);
      @(negedge iClk);
      if (gap > 0) begin
        iValid = 1'b0;
        repeat (gap) @(negedge iClk);
      end
    end
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge iClk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge iClk);
  endtask

  task automatic chkCleared(input string tag);
    chk({tag, "_busy"},  int'(oBusy),  0);
    chk({tag, "_err"},   int'(oErr),   0);
    chk({tag, "_max"},   int'(oMax),   0);
    chk({tag, "_min"},   int'(oMin),   0);
    chk({tag, "_count"}, int'(oCount), 0);
    chk({tag, "_cmp"},   int'({oCmp_a, oCmp_b}), 0);
`ifdef MINMAX_INDEX_EN
    chk({tag, "_idx"},   int'({oMaxIdx, oMinIdx}), 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    iRst = 1'b1; iValid = 1'b0; iData = '0; iLast = 1'b0;
    repeat (3) @(negedge iClk);
    chkCleared("reset");
    chk("reset_done", int'(oDone), 0);
    iRst = 1'b0;
    @(negedge iClk);
    chk("reset_ready", int'(oReady), 1);

    // Directed burst
    q = '{8'hA6, 8'hFF, 8'h92, 8'hD6, 8'hA6};
    sb.push_back(mk(8'hFF, 8'h92, 5, 1, 2));
    sendBurst(q, 1'b1, 0);
    drain();
    chk("busy_after_done", int'(oBusy), 0);
    chk("err_clean", int'(oErr), 0);
    chk("max_held", int'(oMax), 8'hFF);

    // Single-sample burst
    q = '{8'h3C};
    sb.push_back(mk(8'h3C, 8'h3C, 1, 0, 0));
    sendBurst(q, 1'b1, 0);
    drain();

    // Ties keep first occurrence; idle gaps between samples
    q = '{8'h55, 8'h55, 8'h55};
    sb.push_back(mk(8'h55, 8'h55, 3, 0, 0));
    sendBurst(q, 1'b1, 2);
    drain();

    // Back-to-back with iValid held, reference-model checked
    q = '{8'h5A, 8'hC3, 8'h17, 8'hE8, 8'hE8, 8'h02, 8'h9F, 8'h02, 8'h71, 8'hFF, 8'h00, 8'h80};
    sb.push_back(model(q));
    sendBurst(q, 1'b1, 0);
    drain();

    // Count saturation: 260 samples
    q = {};
    for (int i = 0; i < 260; i++) q.push_back(8'(i));
    sb.push_back(model(q));
    sendBurst(q, 1'b1, 0);
    drain();

    // Illegal comparator result on sample 80: no update, sticky error
    badVal = 8'h80; forceBad = 1'b1;
    q = '{8'h40, 8'h80, 8'h20};
    sb.push_back(mk(8'h40, 8'h20, 3, 0, 2));
    sendBurst(q, 1'b1, 0);
    drain();
    forceBad = 1'b0;
    chk("err_set", int'(oErr), 1);
    q = '{8'h01, 8'h02};
    sb.push_back(mk(8'h02, 8'h01, 2, 1, 0));
    sendBurst(q, 1'b1, 0);
    drain();
    chk("err_sticky", int'(oErr), 1);

    // Reset mid-burst discards the partial burst
    q = '{8'h77, 8'h88};
    sendBurst(q, 1'b0, 0);
    iRst = 1'b1;
    @(negedge iClk);
    chkCleared("midrst");
    iRst = 1'b0;
    repeat (5) @(negedge iClk);
    chk("midrst_nodone_busy", int'(oBusy), 0);
    q = '{8'h10, 8'h20};
    sb.push_back(mk(8'h20, 8'h10, 2, 1, 0));
    sendBurst(q, 1'b1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
